// File: rtl/os_processing_element.sv
// Output-stationary MAC cell: pipelined multiplier feeding an accumulator that
// closes a dot product every Thres+1 terms, with act/wei forwarding and a scan chain.
module os_processing_element #(
  parameter int WIDTH_A                     = 16,
  parameter int WIDTH_B                     = 16,
  parameter int WIDTH_MAC                   = 48,
  parameter int WIDTH_T                     = 2,
  parameter int ZERO_GATING_MULT            = 1,
  parameter int ZERO_GATING_ADD             = 1,
  parameter int MM_APPROX                   = 1,
  parameter int M_APPROX                    = 1,
  parameter int AA_APPROX                   = 1,
  parameter int A_APPROX                    = 1,
  parameter int MUL_TYPE                    = 0,
  parameter int ADD_TYPE                    = 0,
  parameter int STAGE                       = 5,
  parameter int ARITHMETIC                  = 0,
  parameter int SIGNED                      = 0,
  parameter int INTERMEDIATE_PIPELINE_STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_A-1:0]   act,
  input  logic [WIDTH_B-1:0]   wei,
  input  logic [WIDTH_MAC-1:0] MAC_IN,
  input  logic                 pipeline_en,
  input  logic                 reg_clear,
  input  logic                 cell_en,
  input  logic                 cell_sc_en,
  input  logic                 c_switch,
  input  logic                 cscan_en,
  input  logic [WIDTH_T-1:0]   Thres,
  output logic                 cell_out,
  output logic                 c_switch_out,
  output logic [WIDTH_A-1:0]   act_out,
  output logic [WIDTH_B-1:0]   wei_out,
  output logic [WIDTH_MAC-1:0] MAC_out
);

  localparam logic [WIDTH_MAC-1:0] ALL_ONES = {WIDTH_MAC{1'b1}};
  localparam logic [WIDTH_MAC-1:0] MUL_MASK = (MUL_TYPE == 1) ? (ALL_ONES << M_APPROX) : ALL_ONES;
  localparam logic [WIDTH_MAC-1:0] ADD_MASK = (ADD_TYPE == 1) ? (ALL_ONES << A_APPROX) : ALL_ONES;
  localparam logic [WIDTH_MAC-1:0] SMAX     = {1'b0, {(WIDTH_MAC-1){1'b1}}};
  localparam logic [WIDTH_MAC-1:0] SMIN     = {1'b1, {(WIDTH_MAC-1){1'b0}}};

  logic [WIDTH_MAC-1:0] actExt, weiExt, mulRaw, stage1_d;
  logic [WIDTH_MAC-1:0] prod_q [STAGE];
  logic [STAGE-1:0]     valid_q, csw_q;
  logic [WIDTH_MAC-1:0] prodAl;
  logic                 validAl, cswAl;
  logic [WIDTH_MAC-1:0] acc_q, macOut_q, termSum, satSum;
  logic [WIDTH_MAC:0]   sumWide;
  logic [WIDTH_T-1:0]   count_q;
  logic                 cellOut_q, cswOut_q, done, accWrite;
  logic [WIDTH_A-1:0]   actOut_q;
  logic [WIDTH_B-1:0]   weiOut_q;

  // Operands are widened to the accumulator width first, so the low bits of the
  // product are correct for both two's-complement and unsigned operands.
  always_comb begin
    actExt = {{(WIDTH_MAC-WIDTH_A){(SIGNED != 0) & act[WIDTH_A-1]}}, act};
    weiExt = {{(WIDTH_MAC-WIDTH_B){(SIGNED != 0) & wei[WIDTH_B-1]}}, wei};
    mulRaw = actExt * weiExt;
    stage1_d = mulRaw & MUL_MASK;
    if ((ZERO_GATING_MULT != 0) && ((act == '0) || (wei == '0))) stage1_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n || reg_clear) begin
      for (int i = 0; i < STAGE; i++) prod_q[i] <= '0;
      valid_q <= '0;
      csw_q   <= '0;
    end else if (pipeline_en) begin
      prod_q[0]  <= stage1_d;
      valid_q[0] <= cell_en;
      csw_q[0]   <= c_switch;
      for (int i = 1; i < STAGE; i++) begin
        prod_q[i]  <= prod_q[i-1];
        valid_q[i] <= valid_q[i-1];
        csw_q[i]   <= csw_q[i-1];
      end
    end
  end

  if (INTERMEDIATE_PIPELINE_STAGE != 0) begin : g_im
    logic [WIDTH_MAC-1:0] imProd_q;
    logic                 imValid_q, imCsw_q;
    always_ff @(posedge clk) begin
      if (rst_n || reg_clear) begin
        imProd_q  <= '0;
        imValid_q <= 1'b0;
        imCsw_q   <= 1'b0;
      end else if (pipeline_en) begin
        imProd_q  <= prod_q[STAGE-1];
        imValid_q <= valid_q[STAGE-1];
        imCsw_q   <= csw_q[STAGE-1];
      end
    end
    assign prodAl  = imProd_q;
    assign validAl = imValid_q;
    assign cswAl   = imCsw_q;
  end else begin : g_no_im
    assign prodAl  = prod_q[STAGE-1];
    assign validAl = valid_q[STAGE-1];
    assign cswAl   = csw_q[STAGE-1];
  end

  // A c_switch arriving without a product closes whatever has been accumulated.
  always_comb begin
    sumWide = {1'b0, acc_q} + {1'b0, prodAl};
    satSum  = sumWide[WIDTH_MAC-1:0];
    if (ARITHMETIC != 0) begin
      if (SIGNED != 0) begin
        if ((acc_q[WIDTH_MAC-1] == prodAl[WIDTH_MAC-1]) &&
            (satSum[WIDTH_MAC-1] != acc_q[WIDTH_MAC-1]))
          satSum = acc_q[WIDTH_MAC-1] ? SMIN : SMAX;
      end else if (sumWide[WIDTH_MAC]) begin
        satSum = ALL_ONES;
      end
    end
    termSum  = validAl ? (satSum & ADD_MASK) : acc_q;
    done     = cswAl || (validAl && (count_q == Thres));
    accWrite = validAl && !((ZERO_GATING_ADD != 0) && (prodAl == '0));
  end

  always_ff @(posedge clk) begin
    if (rst_n || reg_clear) begin
      acc_q     <= '0;
      count_q   <= '0;
      macOut_q  <= '0;
      cellOut_q <= 1'b0;
      cswOut_q  <= 1'b0;
      actOut_q  <= '0;
      weiOut_q  <= '0;
    end else if (pipeline_en) begin
      actOut_q <= act;
      weiOut_q <= wei;
      cswOut_q <= c_switch;
      if (done) begin
        acc_q   <= '0;
        count_q <= '0;
      end else if (validAl) begin
        count_q <= count_q + 1'b1;
        if (accWrite) acc_q <= termSum;
      end
      if (cscan_en && cell_sc_en) begin
        macOut_q  <= MAC_IN;
        cellOut_q <= 1'b0;
      end else if (done && cell_sc_en) begin
        macOut_q  <= termSum;
        cellOut_q <= 1'b1;
      end else begin
        cellOut_q <= 1'b0;
      end
    end
  end

  assign MAC_out      = macOut_q;
  assign cell_out     = cellOut_q;
  assign c_switch_out = cswOut_q;
  assign act_out      = actOut_q;
  assign wei_out      = weiOut_q;

endmodule

// File: tb/tb_os_processing_element.sv
// Scoreboard bench for os_processing_element: stimulus pushes expected dot-product
// results into a queue, a monitor pops and compares on every result pulse.
module tb_os_processing_element;

  localparam int STAGE = 5;
  localparam int WA    = 16;
  localparam int WB    = 16;
  localparam int WM    = 48;
  localparam int WT    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [WA-1:0] act = '0;
  logic [WB-1:0] wei = '0;
  logic [WM-1:0] MAC_IN = '0;
  logic          pipeline_en = 1'b1;
  logic          reg_clear = 1'b0;
  logic          cell_en = 1'b1;
  logic          cell_sc_en = 1'b1;
  logic          c_switch = 1'b0;
  logic          cscan_en = 1'b0;
  logic [WT-1:0] Thres = '0;
  logic          cell_out, c_switch_out;
  logic [WA-1:0] act_out;
  logic [WB-1:0] wei_out;
  logic [WM-1:0] MAC_out;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  logic [WM-1:0] expQ[$];
  logic [WM-1:0] modelAcc = '0;
  logic [WT-1:0] modelCnt = '0;

  os_processing_element #(.SIGNED(1), .STAGE(STAGE)) dut (
    .clk(clk), .rst_n(rst_n), .act(act), .wei(wei), .MAC_IN(MAC_IN),
    .pipeline_en(pipeline_en), .reg_clear(reg_clear), .cell_en(cell_en),
    .cell_sc_en(cell_sc_en), .c_switch(c_switch), .cscan_en(cscan_en),
    .Thres(Thres), .cell_out(cell_out), .c_switch_out(c_switch_out),
    .act_out(act_out), .wei_out(wei_out), .MAC_out(MAC_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WM-1:0] got, input logic [WM-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Drives one cycle of inputs and advances the bench's own accumulation model.
  task automatic applyStimulus(input logic [WA-1:0] a, input logic [WB-1:0] w,
                               input logic en, input logic csw);
    longint p;
    logic [WM-1:0] sum;
    act = a; wei = w; cell_en = en; c_switch = csw;
    if (!rst_n && !reg_clear && pipeline_en && en) begin
      p   = longint'($signed(a)) * longint'($signed(w));
      sum = modelAcc + p[WM-1:0];
      if ((modelCnt == Thres) || csw) begin
        if (cell_sc_en) expQ.push_back(sum);
        modelAcc = '0;
        modelCnt = '0;
      end else begin
        modelAcc = sum;
        modelCnt = modelCnt + 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mac"}, MAC_out, '0);
    checkOutput({tag, "_cell_out"}, WM'(cell_out), '0);
    checkOutput({tag, "_act_out"}, WM'(act_out), '0);
    checkOutput({tag, "_wei_out"}, WM'(wei_out), '0);
    checkOutput({tag, "_csw_out"}, WM'(c_switch_out), '0);
  endtask

  // Monitor: a result counts only if the last edge actually advanced the pipeline.
  initial begin : monitor
    bit advanced;
    logic [WM-1:0] e;
    forever begin
      @(posedge clk);
      advanced = pipeline_en && !rst_n && !reg_clear;
      @(negedge clk);
      if (advanced && cell_out) begin
        checks++;
        pulseCount++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result: got %0h, expected no result", MAC_out);
        end else begin
          e = expQ.pop_front();
          if (MAC_out !== e) begin
            errors++;
            $display("[TB] FAIL result: got %0h, expected %0h", MAC_out, e);
          end
        end
      end
      if (rst_n || reg_clear) expQ.delete();
    end
  end

  initial begin : stimulus
    logic [WM-1:0] macSnap;
    logic          cellSnap;
    logic [WA-1:0] actSnap;
    int            pulsesBefore;

    for (int i = 0; i < STAGE + 1; i++) applyStimulus(16'd1, 16'd1, 1'b1, 1'b0);
    checkAllZero("reset_1");
    for (int i = 0; i < STAGE + 1; i++) applyStimulus(16'd2, 16'd2, 1'b1, 1'b0);
    checkAllZero("reset_2");

    rst_n = 1'b0;
    for (int i = 0; i < STAGE + 3; i++) applyStimulus(16'd1, 16'd1, 1'b1, 1'b0);
    checkOutput("run1_mac", MAC_out, 48'd1);
    checkOutput("run1_cell_out", WM'(cell_out), 48'd1);
    checkOutput("run1_act_out", WM'(act_out), 48'd1);
    checkOutput("run1_wei_out", WM'(wei_out), 48'd1);
    checkOutput("run1_csw_out", WM'(c_switch_out), 48'd0);

    reg_clear = 1'b1;
    modelAcc = '0; modelCnt = '0;
    for (int i = 0; i < STAGE + 3; i++) applyStimulus(16'd1, 16'd1, 1'b1, 1'b0);
    checkAllZero("clear");
    reg_clear = 1'b0;
    for (int i = 0; i < STAGE + 3; i++) applyStimulus(16'd2, 16'd2, 1'b1, 1'b0);
    checkOutput("run2_mac", MAC_out, 48'd4);
    checkOutput("run2_cell_out", WM'(cell_out), 48'd1);
    checkOutput("run2_act_out", WM'(act_out), 48'd2);
    checkOutput("run2_wei_out", WM'(wei_out), 48'd2);

    drain(STAGE + 2);
    Thres = 2'd1;
    pulsesBefore = pulseCount;
    applyStimulus(16'd3, 16'd1, 1'b1, 1'b0);
    applyStimulus(16'd5, 16'd1, 1'b1, 1'b0);
    applyStimulus(16'd2, 16'd1, 1'b1, 1'b0);
    applyStimulus(16'd1, 16'd2, 1'b1, 1'b0);
    drain(STAGE + 2);
    checkOutput("thres1_pulses", WM'(pulseCount - pulsesBefore), 48'd2);
    checkOutput("thres1_last_mac", MAC_out, 48'd4);

    Thres = 2'd3;
    pulsesBefore = pulseCount;
    applyStimulus(16'd7, 16'd1, 1'b1, 1'b0);
    applyStimulus(16'd6, 16'd1, 1'b1, 1'b1);
    checkOutput("csw_out", WM'(c_switch_out), 48'd1);
    drain(STAGE + 2);
    checkOutput("csw_pulses", WM'(pulseCount - pulsesBefore), 48'd1);
    checkOutput("csw_mac", MAC_out, 48'd13);

    cscan_en = 1'b1;
    MAC_IN = 48'hABC;
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("scan_mac", MAC_out, 48'hABC);
    checkOutput("scan_cell_out", WM'(cell_out), 48'd0);
    cscan_en = 1'b0;

    Thres = 2'd0;
    applyStimulus(16'hFFFE, 16'd3, 1'b1, 1'b0);
    applyStimulus(16'd4, 16'd5, 1'b1, 1'b0);
    applyStimulus(16'd4, 16'd5, 1'b1, 1'b0);
    pipeline_en = 1'b0;
    macSnap = MAC_out; cellSnap = cell_out; actSnap = act_out;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'd9, 16'd9, 1'b1, 1'b0);
      checkOutput("hold_mac", MAC_out, macSnap);
      checkOutput("hold_cell_out", WM'(cell_out), WM'(cellSnap));
      checkOutput("hold_act_out", WM'(act_out), WM'(actSnap));
    end
    checkOutput("hold_act_value", WM'(actSnap), 48'd4);
    pipeline_en = 1'b1;
    pulsesBefore = pulseCount;
    applyStimulus(16'd1, 16'd1, 1'b1, 1'b0);
    drain(STAGE + 2);
    checkOutput("signed_pulses", WM'(pulseCount - pulsesBefore), 48'd4);
    checkOutput("signed_last_mac", MAC_out, 48'd1);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queue_empty", WM'(expQ.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
